// File: rtl/exec_result_pipe.sv
// Result staging pipe: execution units inject results at fixed
// stages; entries shift to writeback and are visible for forwarding.
module exec_result_pipe #(
  parameter int DATA_W              = 128,
  parameter int ADDR_W              = 7,
  parameter int DEPTH               = 7,
  parameter int NUM_UNITS           = 4,
  parameter int UNIT_LAT [NUM_UNITS] = '{7, 4, 4, 2}
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_UNITS-1:0]        u_valid,
  input  logic [NUM_UNITS*DATA_W-1:0] u_data,
  input  logic [NUM_UNITS*ADDR_W-1:0] u_addr,
  input  logic                        flush,
  input  logic [ADDR_W-1:0]           q_addr,
  output logic                        q_hit,
  output logic [DATA_W-1:0]           q_data,
  output logic [DEPTH-1:0]            fwd_valid,
  output logic [DEPTH*ADDR_W-1:0]     fwd_addr,
  output logic [DEPTH*DATA_W-1:0]     fwd_data,
  output logic                        wb_valid,
  output logic [ADDR_W-1:0]           wb_addr,
  output logic [DATA_W-1:0]           wb_data,
  output logic                        collision,
  output logic                        overwrite,
  output logic [7:0]                  err_cnt
);

  logic [DEPTH:1]    vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q [1:DEPTH];
  logic [ADDR_W-1:0] addr_d [1:DEPTH];
  logic [DATA_W-1:0] data_q [1:DEPTH];
  logic [DATA_W-1:0] data_d [1:DEPTH];
  logic [DEPTH:1]    inj;
  logic [7:0]        coll_cnt, ovw_cnt;
  logic [9:0]        err_sum;
  logic              collision_q, collision_d;
  logic              overwrite_q, overwrite_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  // Next-state: shift, unit injection with arbitration, flush override
  always_comb begin
    vld_d     = '0;
    inj       = '0;
    coll_cnt  = '0;
    ovw_cnt   = '0;
    addr_d[1] = '0;
    data_d[1] = '0;
    for (int k = 2; k <= DEPTH; k++) begin
      vld_d[k]  = vld_q[k-1];
      addr_d[k] = addr_q[k-1];
      data_d[k] = data_q[k-1];
    end
    for (int k = 1; k <= DEPTH; k++) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (u_valid[u] && UNIT_LAT[u] == k) begin
          if (!inj[k]) begin
            inj[k]    = 1'b1;
            vld_d[k]  = 1'b1;
            addr_d[k] = u_addr[u*ADDR_W +: ADDR_W];
            data_d[k] = u_data[u*DATA_W +: DATA_W];
          end else begin
            coll_cnt = coll_cnt + 8'd1;
          end
        end
      end
      if (k > 1) begin
        if (inj[k] && vld_q[k-1]) begin
          ovw_cnt = ovw_cnt + 8'd1;
        end
      end
    end
    if (flush) begin
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k]  = 1'b0;
        addr_d[k] = '0;
        data_d[k] = '0;
      end
      vld_d[DEPTH]  = vld_q[DEPTH-1];
      addr_d[DEPTH] = addr_q[DEPTH-1];
      data_d[DEPTH] = data_q[DEPTH-1];
      coll_cnt      = '0;
      ovw_cnt       = '0;
    end
    collision_d = (coll_cnt != 8'd0);
    overwrite_d = (ovw_cnt != 8'd0);
    err_sum     = {2'b00, err_cnt_q} + {2'b00, coll_cnt}
                + {2'b00, ovw_cnt};
    err_cnt_d   = (err_sum > 10'd255) ? 8'd255 : err_sum[7:0];
  end

  // Stage and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      collision_q <= 1'b0;
      overwrite_q <= 1'b0;
      err_cnt_q   <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      vld_q       <= vld_d;
      collision_q <= collision_d;
      overwrite_q <= overwrite_d;
      err_cnt_q   <= err_cnt_d;
      for (int k = 1; k <= DEPTH; k++) begin
        addr_q[k] <= addr_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  // Forwarding lookup: youngest (lowest stage) valid match wins
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (vld_q[k] && addr_q[k] == q_addr) begin
        q_hit  = 1'b1;
        q_data = data_q[k];
      end
    end
    if (reset) begin
      q_hit  = 1'b0;
      q_data = '0;
    end
  end

  // Flatten stage contents onto the forwarding bus
  always_comb begin
    fwd_valid = '0;
    fwd_addr  = '0;
    fwd_data  = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      fwd_valid[k-1]               = vld_q[k];
      fwd_addr[(k-1)*ADDR_W +: ADDR_W] = addr_q[k];
      fwd_data[(k-1)*DATA_W +: DATA_W] = data_q[k];
    end
  end

  assign wb_valid  = vld_q[DEPTH];
  assign wb_addr   = addr_q[DEPTH];
  assign wb_data   = data_q[DEPTH];
  assign collision = collision_q;
  assign overwrite = overwrite_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_exec_result_pipe.sv
// Directed bench for exec_result_pipe with default parameters
// (DEPTH 7, unit latencies 7,4,4,2).
module tb_exec_result_pipe;

  localparam int DW = 128;
  localparam int AW = 7;
  localparam int D  = 7;
  localparam int NU = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NU-1:0]   u_valid;
  logic [NU*DW-1:0] u_data;
  logic [NU*AW-1:0] u_addr;
  logic            flush;
  logic [AW-1:0]   q_addr;
  logic            q_hit;
  logic [DW-1:0]   q_data;
  logic [D-1:0]    fwd_valid;
  logic [D*AW-1:0] fwd_addr;
  logic [D*DW-1:0] fwd_data;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic            collision;
  logic            overwrite;
  logic [7:0]      err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  exec_result_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .u_valid   (u_valid),
    .u_data    (u_data),
    .u_addr    (u_addr),
    .flush     (flush),
    .q_addr    (q_addr),
    .q_hit     (q_hit),
    .q_data    (q_data),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .collision (collision),
    .overwrite (overwrite),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    u_valid = '0;
    u_data  = '0;
    u_addr  = '0;
    flush   = 1'b0;
  endtask

  task automatic put(input int u, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    u_valid[u]         = 1'b1;
    u_addr[u*AW +: AW] = a;
    u_data[u*DW +: DW] = d;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    reset  = 1'b1;
    q_addr = '0;
    idle();
    tick();
    tick();
    chk("rst_fwd_valid", DW'(fwd_valid), '0);
    chk("rst_wb_valid", DW'(wb_valid), '0);
    chk("rst_collision", DW'(collision), '0);
    chk("rst_err_cnt", DW'(err_cnt), '0);
    chk("rst_q_hit", DW'(q_hit), '0);
    reset = 1'b0;
    tick();
    chk("post_rst_q_hit", DW'(q_hit), '0);

    // unit 3 (lat 2): stage 2 next cycle, writeback 5 cycles later
    put(3, 7'd5, 128'hAA);
    tick();
    idle();
    chk("lat_stage2", DW'(fwd_valid), 128'b0000010);
    q_addr = 7'd5;
    #1;
    chk("q_hit_5", DW'(q_hit), 1);
    chk("q_data_5", q_data, 128'hAA);
    q_addr = 7'd6;
    #1;
    chk("q_miss_hit", DW'(q_hit), 0);
    chk("q_miss_data", q_data, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("wb_early", DW'(wb_valid), 0);
    tick();
    chk("wb_valid", DW'(wb_valid), 1);
    chk("wb_addr", DW'(wb_addr), 5);
    chk("wb_data", wb_data, 128'hAA);
    tick();
    chk("wb_late", DW'(wb_valid), 0);
    drain();

    // units 1 and 2 collide on stage 4
    put(1, 7'd9, 128'h11);
    put(2, 7'd10, 128'h22);
    tick();
    idle();
    chk("coll_pulse", DW'(collision), 1);
    chk("coll_err", DW'(err_cnt), 1);
    chk("coll_fwd_v", DW'(fwd_valid), 128'b0001000);
    chk("coll_addr4", DW'(fwd_addr[3*AW +: AW]), 9);
    chk("coll_data4", fwd_data[3*DW +: DW], 128'h11);
    tick();
    chk("coll_clear", DW'(collision), 0);
    drain();

    // unit 1 injects into stage 4 over an entry in stage 3
    put(3, 7'd3, 128'h33);
    tick();
    idle();
    tick();
    put(1, 7'd4, 128'h44);
    tick();
    idle();
    chk("ovw_pulse", DW'(overwrite), 1);
    chk("ovw_no_coll", DW'(collision), 0);
    chk("ovw_err", DW'(err_cnt), 2);
    chk("ovw_fwd_v", DW'(fwd_valid), 128'b0001000);
    chk("ovw_addr4", DW'(fwd_addr[3*AW +: AW]), 4);
    tick();
    chk("ovw_clear", DW'(overwrite), 0);
    drain();

    // same address in stage 3 and stage 7: youngest wins
    put(3, 7'd8, 128'h55);
    tick();
    idle();
    put(0, 7'd8, 128'h66);
    tick();
    idle();
    q_addr = 7'd8;
    #1;
    chk("young_hit", DW'(q_hit), 1);
    chk("young_data", q_data, 128'h55);
    chk("young_no_ovw", DW'(overwrite), 0);
    chk("old_wb_data", wb_data, 128'h66);
    drain();

    // flush with entries in stages 2 and 6
    put(3, 7'd12, 128'h77);
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    put(3, 7'd13, 128'h88);
    tick();
    idle();
    chk("pre_flush_v", DW'(fwd_valid), 128'b0100010);
    flush = 1'b1;
    put(1, 7'd20, 128'h1);
    put(2, 7'd21, 128'h2);
    tick();
    idle();
    chk("flush_fwd_v", DW'(fwd_valid), 128'b1000000);
    chk("flush_wb_addr", DW'(wb_addr), 12);
    chk("flush_wb_data", wb_data, 128'h77);
    chk("flush_no_coll", DW'(collision), 0);
    chk("flush_err", DW'(err_cnt), 2);
    tick();
    chk("flush_empty", DW'(fwd_valid), 0);

    // 300 forced collisions saturate the counter
    for (int i = 0; i < 300; i++) begin
      put(1, 7'd1, 128'h1);
      put(2, 7'd2, 128'h2);
      tick();
    end
    chk("sat_err", DW'(err_cnt), 255);
    chk("sat_coll", DW'(collision), 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_err", DW'(err_cnt), 0);
    chk("mid_rst_wb", DW'(wb_valid), 0);
    chk("mid_rst_fwd", DW'(fwd_valid), 0);
    chk("mid_rst_coll", DW'(collision), 0);
    reset = 1'b0;
    idle();
    q_addr = 7'd1;
    tick();
    chk("after_rst_hit", DW'(q_hit), 0);
    chk("after_rst_err", DW'(err_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_result_pipe.md
EXEC_RESULT_PIPE -- requirements
Module: exec_result_pipe

Interface
REQ-001 Parameter DATA_W, 128, result width.
REQ-002 Parameter ADDR_W, 7, destination register address width.
REQ-003 Parameter DEPTH, 7, number of result staging stages (legal 2..16).
REQ-004 Parameter NUM_UNITS, 4, number of execution units feeding the pipe (legal 1..8).
REQ-005 Parameter UNIT_LAT, {7,4,4,2} for units 0..3, injection stage of unit i (legal 1..DEPTH).
REQ-006 clk  in  1  clock; reset reset, synchronous, active-high; all state changes on posedge clk.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 u_valid  in  NUM_UNITS  unit i presents a result this cycle.
REQ-009 u_data  in  NUM_UNITS*DATA_W  unit results, unit i at slice i.
REQ-010 u_addr  in  NUM_UNITS*ADDR_W  unit destination addresses.
REQ-011 flush  in  1  discard all uncommitted results.
REQ-012 q_addr  in  ADDR_W  forwarding lookup address.
REQ-013 q_hit / q_data  out  1 / DATA_W  lookup result, combinational.
REQ-014 fwd_valid / fwd_addr / fwd_data  out  DEPTH / DEPTH*ADDR_W / DEPTH*DATA_W  contents of stages 1..DEPTH.
REQ-015 wb_valid / wb_addr / wb_data  out  1 / ADDR_W / DATA_W  stage DEPTH contents (register-file write).
REQ-016 collision  out  1  one-cycle pulse: injection lost to another unit.
REQ-017 overwrite  out  1  one-cycle pulse: in-flight entry displaced by injection.
REQ-018 err_cnt  out  8  saturating count of dropped results.

Function
REQ-019 Stage k (1..DEPTH) holds {valid, addr, data}; wb_* are stage DEPTH directly, no extra register.
REQ-020 Default each cycle: stage k <= stage k-1; stage 1 <= empty (valid 0, addr 0, data 0).
REQ-021 If any unit with UNIT_LAT==k has u_valid=1, stage k <= that unit's {1, addr, data} instead of shifting.
REQ-022 Latency: result presented at cycle t by unit with latency k is in stage k at t+1, on wb_* at t+1+DEPTH-k.
REQ-023 Multiple valid units with same UNIT_LAT in one cycle: lowest index wins; others dropped; collision=1 that cycle.
REQ-024 Injection into stage k while stage k-1 valid: stage k-1 entry lost; overwrite=1 that cycle.
REQ-025 err_cnt += (dropped collision units + displaced entries) per cycle, saturates at 255, never wraps.
REQ-026 flush=1: stages 1..DEPTH-1 load empty next cycle; stage DEPTH loads stage DEPTH-1's current contents (in-flight commit); all injections in that cycle ignored; no collision/overwrite/err_cnt update.
REQ-027 Lookup: q_hit=1 iff some valid stage has addr==q_addr; q_data = data of lowest-index (youngest) match; q_hit=0 -> q_data=0.
REQ-028 Invalid stages never match, including addr 0.
REQ-029 Outputs depend only on registered state plus q_addr; no u_* -> output combinational path.

Reset
REQ-030 reset=1: all stages valid 0, addr 0, data 0; collision 0, overwrite 0, err_cnt 0 at next edge.
REQ-031 reset dominates flush and injections; results presented during reset are discarded, not counted.
REQ-032 q_hit=0 throughout reset and the first cycle after it.

Verification (DEPTH=7, UNIT_LAT={7,4,4,2})
REQ-033 Unit 3 valid, addr 5, data 0xAA at cycle 0 -> stage 2 at cycle 1, wb_valid=1, wb_addr=5, wb_data=0xAA at cycle 6 only.
REQ-034 Units 1 and 2 valid same cycle, addrs 9/10 -> addr 9 reaches stage 4, collision=1 for one cycle, err_cnt=1.
REQ-035 Unit 3 injects addr 3 at cycle 0; unit 1 injects addr 4 at cycle 2 -> addr 3 lost, overwrite=1, err_cnt increments by 1.
REQ-036 Unit 3 addr 8 at cycle 0, unit 0 addr 8 at cycle 1 -> at cycle 2 q_addr=8 returns unit-3 data (stage 3, younger than stage 7).
REQ-037 Entries in stages 2 and 6, flush=1 -> next cycle stage-6 entry in stage 7 and on wb_*, all other stages invalid.
REQ-038 300 forced collisions -> err_cnt holds 255; reset mid-stream -> err_cnt 0, wb_valid 0 next cycle.
